// File: rtl/truth_table_sweep_ctrl_if.sv
// Host/gate-side signal bundle for the truth-table sweep sequencer.
// The master side is the test host plus gate under test; the slave side is the sequencer.
interface truth_table_sweep_ctrl_if #(
  parameter int N_IN = 3
);
  localparam int TW = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_out;
  logic            match;
  logic [N_IN:0]   mismatch_count;

  modport master (
    output start,
    output abort,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  table_out,
    input  match,
    input  mismatch_count
  );

  modport slave (
    input  start,
    input  abort,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output table_out,
    output match,
    output mismatch_count
  );
endinterface

// File: rtl/truth_table_sweep_ctrl.sv
// Walks every input code of a combinational gate, samples its output and grades the table.
// Define TT_SWEEP_CONTINUOUS_EN to make sweeps repeat back to back until abort or reset.
module truth_table_sweep_ctrl #(
  parameter int                  N_IN          = 3,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECTED     = 8'hB5
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_sweep_ctrl_if.slave bus
);

  localparam int TW = 1 << N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, stateNext;
  logic [N_IN-1:0] vec, vecNext;
  logic [CW-1:0]   cnt, cntNext;
  logic [N_IN-1:0] dutIn, dutInNext;
  logic [TW-1:0]   tableReg, tableNext;
  logic            matchReg, matchNext;
  logic [N_IN:0]   mcountReg, mcountNext;

  function automatic logic [N_IN:0] popCount(input logic [TW-1:0] v);
    logic [N_IN:0] sum;
    sum = '0;
    for (int i = 0; i < TW; i++) begin
      sum = sum + {{N_IN{1'b0}}, v[i]};
    end
    return sum;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      dutIn     <= '0;
      tableReg  <= '0;
      matchReg  <= 1'b0;
      mcountReg <= '0;
    end else begin
      state     <= stateNext;
      vec       <= vecNext;
      cnt       <= cntNext;
      dutIn     <= dutInNext;
      tableReg  <= tableNext;
      matchReg  <= matchNext;
      mcountReg <= mcountNext;
    end
  end

  // Grading happens on the SAMPLE edge of the last row so match/mismatch_count appear alongside done.
  always_comb begin
    stateNext  = state;
    vecNext    = vec;
    cntNext    = cnt;
    dutInNext  = dutIn;
    tableNext  = tableReg;
    matchNext  = matchReg;
    mcountNext = mcountReg;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          stateNext = SETTLE;
          vecNext   = '0;
          cntNext   = '0;
          dutInNext = '0;
          tableNext = '0;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          stateNext = IDLE;
          vecNext   = '0;
          cntNext   = '0;
          dutInNext = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = SAMPLE;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          stateNext = IDLE;
          vecNext   = '0;
          cntNext   = '0;
          dutInNext = '0;
        end else begin
          tableNext[vec] = bus.dut_out;
          if (&vec) begin
            stateNext  = DONE;
            matchNext  = (tableNext == EXPECTED);
            mcountNext = popCount(tableNext ^ EXPECTED);
          end else begin
            stateNext = SETTLE;
            vecNext   = vec + N_IN'(1);
            dutInNext = vec + N_IN'(1);
            cntNext   = '0;
          end
        end
      end
      DONE: begin
`ifdef TT_SWEEP_CONTINUOUS_EN
        if (bus.abort) begin
          stateNext = IDLE;
          vecNext   = '0;
          cntNext   = '0;
          dutInNext = '0;
        end else begin
          stateNext = SETTLE;
          vecNext   = '0;
          cntNext   = '0;
          dutInNext = '0;
          tableNext = '0;
        end
`else
        stateNext = IDLE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.dut_in         = dutIn;
  assign bus.done           = (state == DONE);
  assign bus.table_out      = tableReg;
  assign bus.match          = matchReg;
  assign bus.mismatch_count = mcountReg;
`ifdef TT_SWEEP_CONTINUOUS_EN
  assign bus.busy = (state == SETTLE) || (state == SAMPLE) || (state == DONE);
`else
  assign bus.busy = (state == SETTLE) || (state == SAMPLE);
`endif

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Scoreboard bench: a gate model answers dut_in, expected gradings are queued at start, monitors grade done pulses.
// Runs a default instance plus a SETTLE_CYCLES=1 instance.
module tb_truth_table_sweep_ctrl;

  localparam int          N_IN     = 3;
  localparam int          TW       = 1 << N_IN;
  localparam int          S0       = 4;
  localparam int          S1       = 1;
  localparam logic [7:0]  EXPECTED = 8'hB5;
  localparam int          LAT0     = TW * (S0 + 1);
  localparam int          LAT1     = TW * (S1 + 1);

  typedef struct {
    logic [7:0] tbl;
    logic       match;
    int         mcount;
    int         doneCycle;
  } txn_t;

  logic clk;
  logic reset;
  int   cycle;
  int   checks;
  int   failures;

  logic [TW-1:0] gateTable0;
  logic [TW-1:0] gateTable1;
  txn_t          q0[$];
  txn_t          q1[$];
  logic          lastMatch;
  int            lastMcount;

  truth_table_sweep_ctrl_if #(.N_IN(N_IN)) ifc0 ();
  truth_table_sweep_ctrl_if #(.N_IN(N_IN)) ifc1 ();

  truth_table_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(S0), .EXPECTED(EXPECTED)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc0.slave)
  );

  truth_table_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(S1), .EXPECTED(EXPECTED)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1.slave)
  );

  // The gate under test is an ideal lookup table indexed by the applied input code.
  assign ifc0.dut_out = gateTable0[ifc0.dut_in];
  assign ifc1.dut_out = gateTable1[ifc1.dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (ifc0.done === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("unexpected_done0", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = q0.pop_front();
        checkOutput("table0", 32'(ifc0.table_out), 32'(t.tbl));
        checkOutput("match0", 32'(ifc0.match), 32'(t.match));
        checkOutput("mcount0", 32'(ifc0.mismatch_count), 32'(t.mcount));
        checkOutput("latency0", 32'(cycle), 32'(t.doneCycle));
      end
    end
  end

  always @(negedge clk) begin
    if (ifc1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_done1", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = q1.pop_front();
        checkOutput("table1", 32'(ifc1.table_out), 32'(t.tbl));
        checkOutput("match1", 32'(ifc1.match), 32'(t.match));
        checkOutput("mcount1", 32'(ifc1.mismatch_count), 32'(t.mcount));
        checkOutput("latency1", 32'(cycle), 32'(t.doneCycle));
      end
    end
  end

  // Rows fully sampled before an abort seen after edge m survive; later rows read 0.
  function automatic logic [7:0] partialTable(input logic [7:0] gate, input int m, input int s);
    int rows;
    logic [8:0] mask;
    rows = m / (s + 1);
    mask = (9'd1 << rows) - 9'd1;
    return gate & mask[7:0];
  endfunction

  task automatic applyStimulus(input logic [7:0] gate, input int abortAt, input int resetAt, input int restartAt);
    int c;
    @(negedge clk);
    gateTable0 = gate;
    ifc0.start = 1'b1;
    c = cycle;
    if (abortAt < 0 && resetAt < 0) begin
      q0.push_back('{gate, (gate == EXPECTED), $countones(gate ^ EXPECTED), c + 1 + LAT0});
    end
    @(negedge clk);
    ifc0.start = 1'b0;
    for (int m = 0; m < LAT0; m++) begin
      checkOutput("dut_in_step", 32'(ifc0.dut_in), 32'(m / (S0 + 1)));
      checkOutput("busy_sweep", 32'(ifc0.busy), 32'd1);
      ifc0.start = (m == restartAt);
      ifc0.abort = (m == abortAt);
      reset      = (m == resetAt);
      @(negedge clk);
      ifc0.start = 1'b0;
      ifc0.abort = 1'b0;
      if (m == abortAt) begin
        checkOutput("abort_busy", 32'(ifc0.busy), 32'd0);
        checkOutput("abort_done", 32'(ifc0.done), 32'd0);
        checkOutput("abort_dut_in", 32'(ifc0.dut_in), 32'd0);
        checkOutput("abort_table", 32'(ifc0.table_out), 32'(partialTable(gate, m, S0)));
        checkOutput("abort_match", 32'(ifc0.match), 32'(lastMatch));
        checkOutput("abort_mcount", 32'(ifc0.mismatch_count), 32'(lastMcount));
        return;
      end
      if (m == resetAt) begin
        reset = 1'b0;
        checkOutput("rst_dut_in", 32'(ifc0.dut_in), 32'd0);
        checkOutput("rst_busy", 32'(ifc0.busy), 32'd0);
        checkOutput("rst_done", 32'(ifc0.done), 32'd0);
        checkOutput("rst_table", 32'(ifc0.table_out), 32'd0);
        checkOutput("rst_match", 32'(ifc0.match), 32'd0);
        checkOutput("rst_mcount", 32'(ifc0.mismatch_count), 32'd0);
        lastMatch  = 1'b0;
        lastMcount = 0;
        return;
      end
    end
    for (int i = 0; i < 20 && q0.size() != 0; i++) @(negedge clk);
    if (q0.size() != 0) begin
      checkOutput("done0_timeout", 32'd0, 32'd1);
      q0.delete();
    end
    lastMatch  = (gate == EXPECTED);
    lastMcount = $countones(gate ^ EXPECTED);
`ifdef TT_SWEEP_CONTINUOUS_EN
    ifc0.abort = 1'b1;
    @(negedge clk);
    ifc0.abort = 1'b0;
`endif
  endtask

  task automatic applyStimulusShort(input logic [7:0] gate);
    int c;
    @(negedge clk);
    gateTable1 = gate;
    ifc1.start = 1'b1;
    c = cycle;
    q1.push_back('{gate, (gate == EXPECTED), $countones(gate ^ EXPECTED), c + 1 + LAT1});
    @(negedge clk);
    ifc1.start = 1'b0;
    for (int m = 0; m < LAT1; m++) begin
      checkOutput("dut_in_step1", 32'(ifc1.dut_in), 32'(m / (S1 + 1)));
      @(negedge clk);
    end
    for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      checkOutput("done1_timeout", 32'd0, 32'd1);
      q1.delete();
    end
`ifdef TT_SWEEP_CONTINUOUS_EN
    ifc1.abort = 1'b1;
    @(negedge clk);
    ifc1.abort = 1'b0;
`endif
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cycle      = 0;
    lastMatch  = 1'b0;
    lastMcount = 0;
    gateTable0 = EXPECTED;
    gateTable1 = EXPECTED;
    reset      = 1'b1;
    ifc0.start = 1'b0;
    ifc0.abort = 1'b0;
    ifc1.start = 1'b0;
    ifc1.abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_dut_in", 32'(ifc0.dut_in), 32'd0);
    checkOutput("reset_busy", 32'(ifc0.busy), 32'd0);
    checkOutput("reset_done", 32'(ifc0.done), 32'd0);
    checkOutput("reset_table", 32'(ifc0.table_out), 32'd0);
    checkOutput("reset_match", 32'(ifc0.match), 32'd0);
    checkOutput("reset_mcount", 32'(ifc0.mismatch_count), 32'd0);

    applyStimulus(8'hB5, -1, -1, -1);
    applyStimulus(8'h96, -1, -1, -1);
    applyStimulus(8'hB5, 3 * (S0 + 1) + 1, -1, -1);
    applyStimulus(8'h5A, -1, 20, 10);
    applyStimulus(8'hB5, -1, -1, 10);
    applyStimulus(8'h00, -1, -1, -1);
    applyStimulus(8'hFF, LAT0 - 1, -1, -1);

    for (int t = 0; t < 12; t++) begin
      logic [7:0] g;
      g = 8'($urandom);
      if ($urandom_range(0, 2) == 0) applyStimulus(g, $urandom_range(0, LAT0 - 1), -1, -1);
      else applyStimulus(g, -1, -1, $urandom_range(0, 30));
    end

    applyStimulusShort(8'hB5);
    for (int t = 0; t < 4; t++) begin
      logic [7:0] g;
      g = 8'($urandom);
      applyStimulusShort(g);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
